// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and counter sizing helper
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit a - b - bin cell with borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, valid/ready on both sides
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_bin,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_diff,
  output logic             io_out_borrow,
  output logic             io_out_overflow
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, result;
  logic [CW-1:0] cnt;
  logic borrow, a_msb, b_msb, d, bo, last;
  full_subtractor u_fs (.a(a_sr[0]), .b(b_sr[0]), .bin(borrow), .d(d), .bout(bo));
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nx = state == IDLE ? (io_in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (io_out_ready ? IDLE : DONE);
    io_in_ready = state == IDLE;
    io_out_valid = state == DONE;
    io_out_diff = result;
    io_out_borrow = borrow;
    io_out_overflow = (a_msb != b_msb) && (result[WIDTH-1] != a_msb);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      result <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && io_in_valid) begin
        a_sr <= io_in_a;
        b_sr <= io_in_b;
        borrow <= io_in_bin;
        a_msb <= io_in_a[WIDTH-1];
        b_msb <= io_in_b[WIDTH-1];
        result <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        result <= {d, result[WIDTH-1:1]};
        borrow <= bo;
        cnt <= last ? cnt : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks against an arithmetic reference
module tb_serial_subtractor;
  localparam int W = 8;
  logic clock = 1'b0, reset = 1'b0;
  logic io_in_valid = 1'b0, io_in_ready, io_in_bin = 1'b0;
  logic [W-1:0] io_in_a = '0, io_in_b = '0, io_out_diff;
  logic io_out_valid, io_out_ready = 1'b0, io_out_borrow, io_out_overflow;
  int errors = 0, checks = 0;
  serial_subtractor #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_bin(io_in_bin),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_diff(io_out_diff), .io_out_borrow(io_out_borrow),
    .io_out_overflow(io_out_overflow)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic model(input int a, input int b, input int bin, output logic [W-1:0] d,
                       output logic bo, output logic ov);
    int sa, sb, r;
    d = W'(a - b - bin);
    bo = a < b + bin;
    sa = a >= (1 << (W - 1)) ? a - (1 << W) : a;
    sb = b >= (1 << (W - 1)) ? b - (1 << W) : b;
    r = sa - sb - bin;
    ov = r < -(1 << (W - 1)) || r >= (1 << (W - 1));
  endtask
  // Latency counts the accept edge as the first cycle; noise drives ignored operands mid-op.
  task automatic run_op(input int a, input int b, input int bin, input int stall,
                        input bit chk_lat, input bit noise);
    logic [W-1:0] ed;
    logic eb, eo;
    int n;
    model(a, b, bin, ed, eb, eo);
    n = 0;
    while (!io_in_ready && n < 50) begin tick(); n++; end
    check("in_ready_before_op", io_in_ready, 1);
    io_in_a = W'(a);
    io_in_b = W'(b);
    io_in_bin = 1'(bin);
    io_in_valid = 1'b1;
    io_out_ready = stall == 0;
    n = 0;
    do begin
      tick();
      n++;
      io_in_valid = noise ? 1'($urandom) : 1'b0;
      io_in_a = W'($urandom);
      io_in_b = W'($urandom);
      io_in_bin = 1'($urandom);
      if (n > 1) check("in_ready_busy", io_in_ready, 0);
    end while (!io_out_valid && n < 50);
    io_in_valid = 1'b0;
    if (chk_lat) check("latency", n, W + 1);
    check("out_valid", io_out_valid, 1);
    check("diff", io_out_diff, ed);
    check("borrow", io_out_borrow, eb);
    check("overflow", io_out_overflow, eo);
    for (int i = 0; i < stall; i++) begin
      io_in_valid = noise ? 1'($urandom) : 1'b0;
      tick();
      check("hold_valid", io_out_valid, 1);
      check("hold_diff", io_out_diff, ed);
      check("hold_borrow", io_out_borrow, eb);
      check("hold_in_ready", io_in_ready, 0);
    end
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    tick();
    check("released_valid", io_out_valid, 0);
    check("released_in_ready", io_in_ready, 1);
  endtask
  initial begin
    tick();
    tick();
    check("rst_in_ready", io_in_ready, 1);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_diff", io_out_diff, 0);
    check("rst_borrow", io_out_borrow, 0);
    check("rst_overflow", io_out_overflow, 0);
    reset = 1'b1;
    tick();
    run_op(8'h05, 8'h03, 0, 0, 1, 0);
    run_op(8'h03, 8'h05, 0, 0, 1, 0);
    run_op(8'h80, 8'h01, 0, 0, 1, 0);
    run_op(8'h7F, 8'hFF, 0, 0, 1, 0);
    run_op(8'h00, 8'h00, 1, 0, 1, 0);
    run_op(8'hFF, 8'hFF, 0, 0, 1, 0);
    run_op(8'hA5, 8'h3C, 1, 5, 1, 1);
    io_in_a = 8'h55;
    io_in_b = 8'h22;
    io_in_valid = 1'b1;
    io_out_ready = 1'b1;
    tick();
    io_in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrun_rst_valid", io_out_valid, 0);
    check("midrun_rst_in_ready", io_in_ready, 1);
    check("midrun_rst_diff", io_out_diff, 0);
    run_op(8'h10, 8'h01, 0, 0, 1, 0);
    for (int i = 0; i < 25; i++)
      run_op(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)),
             int'($urandom_range(3)), 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor that computes diff = a - b - bin, one bit per cycle, LSB first.
- Built around a registered one-bit full-subtractor cell, the borrow-propagating counterpart of the team's full-adder datapath.
- Sits between a producer and a consumer, each using a valid/ready handshake.
- Trades latency for area in arithmetic pipelines that do not need single-cycle subtraction.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..64)

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset=0 clears state at next rising edge)
io_in_valid  input  1  operands present
io_in_ready  output  1  block can accept operands
io_in_a  input  WIDTH  minuend
io_in_b  input  WIDTH  subtrahend
io_in_bin  input  1  initial borrow-in (chaining)
io_out_valid  output  1  result present
io_out_ready  input  1  consumer accepts result
io_out_diff  output  WIDTH  a - b - bin modulo 2^WIDTH
io_out_borrow  output  1  final borrow-out (1 when unsigned a < b + bin)
io_out_overflow  output  1  two's-complement overflow

Behaviour:
- FSM states: IDLE, RUN, DONE. On reset: state=IDLE, io_in_ready=1, io_out_valid=0, io_out_diff=0, io_out_borrow=0, io_out_overflow=0, bit counter=0.
- IDLE:
  - io_in_ready=1.
  - Accept when io_in_valid=1: latch a, b into shift registers, latch bin into the borrow register, latch a[MSB] and b[MSB], clear the result register and counter, then go to RUN.
- RUN:
  - io_in_ready=0, io_out_valid=0.
  - Each cycle, the cell takes x=a_sr[0], y=b_sr[0], bi=borrow.
  - d = x^y^bi.
  - bo = (~x&y) | (~(x^y)&bi).
  - d shifts into the result MSB (result shifts right). a_sr and b_sr shift right. borrow<=bo. counter++.
  - After exactly WIDTH RUN cycles (counter==WIDTH-1 on the last), go to DONE.
- DONE:
  - io_out_valid=1.
  - diff = result register. borrow = final borrow register.
  - overflow = (aMSB != bMSB) && (diff[MSB] != aMSB).
  - Outputs hold stable while io_out_ready=0 (indefinite backpressure).
  - On io_out_valid & io_out_ready, go to IDLE.
  - Outputs in IDLE keep their last values but are qualified only by io_out_valid.
- Latency: accept edge at cycle 0; io_out_valid rises WIDTH+1 cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum.
- Accept and deliver never overlap: no simultaneous in/out handshake is possible. io_in_ready is combinationally (state==IDLE) only.
- io_in_valid while not in IDLE is ignored; operands are not sampled.
- Operand changes after acceptance have no effect.
- Reset asserted in any state (mid-RUN or DONE with pending output) forces IDLE on that edge. The in-flight result is discarded and io_out_valid=0 the next cycle.
- The counter is sized clog2(WIDTH). There is no wrap-around beyond WIDTH-1.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RUN=1, DONE=2) and a clog2 helper for counter width.
- One natural sub-module: full_subtractor (combinational; inputs a, b, bin; outputs d, bout).
  - Instantiated once.
  - Exhaustively testable on its own (8 vectors).
- Top level holds the FSM, shift registers, borrow register and counter.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, out_ready=1 -> diff=0x02, borrow=0, overflow=0; out_valid exactly 9 cycles after the accept edge.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow=1, overflow=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow=0, overflow=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1. Also a=0xFF, b=0xFF, bin=0 -> 0x00, borrow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Toggle in_valid with new operands during RUN -> ignored; first result unchanged. Release -> IDLE, in_ready=1 next cycle.
- Reset=0 on the 4th RUN cycle -> next cycle state IDLE, out_valid=0, in_ready=1. A new operation a=0x10, b=0x01 then yields diff=0x0F.
